hazard_ctrl: RTL and testbench

Stall/flush scheduler for the five-stage pipeline registers (F/D/E/M/W).
- Detects D-stage RAW hazards from Tuse/Tnew.
- Sequences the multi-cycle mult/div unit with an internal busy FSM and countdown.
- Arbitrates exception/interrupt flush (Req) against stalls.
- Drives the en/flush inputs of the D, E, M and W registers and the PC enable.

---
 rtl/hazard_ctrl_pkg.sv | 41 ++++
 rtl/md_busy_fsm.sv | 65 ++++++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - Tuse/Tnew encodings (TUSE_NONE marks an operand that is never read)
//   - mult/div busy FSM states
//   - default mult/div latencies
//   - raw_hazard(): D-stage RAW check of one source operand against E and M
package hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // A producer in E or M stalls the consumer in D when its result arrives later than the
    // consumer needs it. Register 0 is hard-wired and never creates a dependency.
    function automatic logic raw_hazard(
        input logic [4:0] a_src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        // Tnew never exceeds 3, so an unused operand can never stall; the early out keeps
        // that explicit.
        if (a_src == 5'd0 || tuse == TUSE_NONE) begin
            return 1'b0;
        end
        hit_e = (a_src == a3_e) && (tnew_e > tuse);
        hit_m = (a_src == a3_m) && (tnew_m > tuse);
        return hit_e || hit_m;
    endfunction

endpackage

// File: rtl/md_busy_fsm.sv
// md_busy_fsm: busy tracker for the multi-cycle mult/div unit.
//   clk         in   system clock
//   reset       in   asynchronous active-low reset (0 = reset)
//   md_start_E  in   mult/div op valid in E this cycle
//   md_div_E    in   1 = div/divu, 0 = mult/multu
//   Req         in   exception/interrupt flush; suppresses a start in the same cycle
//   md_busy     out  unit busy, registered
// A start loads the countdown with the op latency; md_busy stays high for exactly that many
// cycles. A flush during BUSY does not abort the running op so HI/LO stays consistent.
module md_busy_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_div_E,
    input  logic Req,
    output logic md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A start that coincides with Req belongs to an op being flushed.
                if (md_start_E && !Req) begin
                    cnt_d   = md_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Starts here are impossible: stall_md holds every md op in D while busy.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the F/D/E/M/W pipeline registers.
//   clk, reset                 clock, asynchronous active-low reset (0 = reset)
//   A1_D, A2_D                 rs/rt of the D instruction
//   Tuse_rs_D, Tuse_rt_D       cycles until rs/rt are needed (3 = not used)
//   md_D                       D instruction uses HI/LO or the mult/div unit
//   A3_E, Tnew_E               destination and result latency of the E instruction
//   A3_M, Tnew_M               destination and result latency of the M instruction
//   md_start_E, md_div_E       mult/div op starting in E, and its kind
//   Req                        CP0 exception/interrupt request, taken at M
//   en_F, en_D                 PC and D register enables
//   flush_D/E/M/W              register clears (bubble on E for stalls, all on Req)
//   md_busy                    mult/div unit busy (registered)
//   stall_cnt                  saturating stall counter (only with HAZARD_STATS_EN)
// Build option: define HAZARD_STATS_EN to add the stall_cnt output and its counter.
// Priority is reset > Req > stall > normal flow.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic        md_D,
    input  logic [4:0]  A3_E,
    input  logic [1:0]  Tnew_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic        Req,
    output logic        en_F,
    output logic        en_D,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        flush_W,
    output logic        md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    assign stall_rs = raw_hazard(A1_D, Tuse_rs_D, A3_E, Tnew_E, A3_M, Tnew_M);
    assign stall_rt = raw_hazard(A2_D, Tuse_rt_D, A3_E, Tnew_E, A3_M, Tnew_M);
    // An md op in E is about to occupy the unit, so a following md op must wait as well.
    assign stall_md = md_D && (md_start_E || md_busy);
    assign stall    = stall_rs || stall_rt || stall_md;

    md_busy_fsm #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_fsm (
        .clk        (clk),
        .reset      (reset),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .Req        (Req),
        .md_busy    (md_busy)
    );

    // Req overrides a stall: the stalled instruction is being flushed anyway, and F must
    // advance to fetch the handler.
    always_comb begin
        en_F    = 1'b0;
        en_D    = 1'b0;
        flush_D = 1'b1;
        flush_E = 1'b1;
        flush_M = 1'b1;
        flush_W = 1'b1;
        if (reset) begin
            en_F    = Req || !stall;
            en_D    = Req || !stall;
            flush_D = Req;
            flush_E = Req || stall;
            flush_M = Req;
            flush_W = Req;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && !Req && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Output vector order: {en_F, en_D, flush_D, flush_E, flush_M, flush_W, md_busy}.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1_D, A2_D, A3_E, A3_M;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
    logic        md_D, md_start_E, md_div_E, Req;
    logic        en_F, en_D, flush_D, flush_E, flush_M, flush_W, md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .A1_D       (A1_D),
        .A2_D       (A2_D),
        .Tuse_rs_D  (Tuse_rs_D),
        .Tuse_rt_D  (Tuse_rt_D),
        .md_D       (md_D),
        .A3_E       (A3_E),
        .Tnew_E     (Tnew_E),
        .A3_M       (A3_M),
        .Tnew_M     (Tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .Req        (Req),
        .en_F       (en_F),
        .en_D       (en_D),
        .flush_D    (flush_D),
        .flush_E    (flush_E),
        .flush_M    (flush_M),
        .flush_W    (flush_W),
        .md_busy    (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] V_RUN   = 7'b1100000;
    localparam logic [6:0] V_STALL = 7'b0001000;
    localparam logic [6:0] V_REQ   = 7'b1111110;
    localparam logic [6:0] V_RST   = 7'b0011110;
    localparam logic [6:0] V_BUSY  = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [6:0] observed();
        return {en_F, en_D, flush_D, flush_E, flush_M, flush_W, md_busy};
    endfunction

    task automatic push(input string tag, input logic [6:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare();
        sb_t        e;
        logic [6:0] obs;
        e   = sb_q.pop_front();
        obs = observed();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    // Expect for the current cycle, compared at the falling edge.
    task automatic expect_cyc(input string tag, input logic [6:0] exp);
        push(tag, exp);
        @(negedge clk);
        pop_compare();
    endtask

    // Expect right now, for asynchronous behaviour.
    task automatic expect_now(input string tag, input logic [6:0] exp);
        push(tag, exp);
        #1;
        pop_compare();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        A1_D = 5'd0; A2_D = 5'd0; A3_E = 5'd0; A3_M = 5'd0;
        Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3; Tnew_E = 2'd0; Tnew_M = 2'd0;
        md_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0; Req = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        expect_now("reset_state", V_RST);
        #10;
        reset = 1'b1;
        next_cyc();
        expect_cyc("run_idle", V_RUN);
        next_cyc();

        // Load-use on rs via E
        A3_E = 5'd5; Tnew_E = 2'd2; A1_D = 5'd5; Tuse_rs_D = 2'd0;
        expect_cyc("load_use_stall", V_STALL);
        Tnew_E = 2'd0;
        expect_now("load_use_ready", V_RUN);
        next_cyc();

        // rt hazard via M, then equal Tnew/Tuse is no hazard
        idle_inputs();
        A2_D = 5'd7; Tuse_rt_D = 2'd1; A3_M = 5'd7; Tnew_M = 2'd2;
        expect_cyc("rt_m_stall", V_STALL);
        Tnew_M = 2'd1;
        expect_now("rt_m_equal", V_RUN);
        next_cyc();

        // Register 0 never stalls
        idle_inputs();
        A1_D = 5'd0; A3_E = 5'd0; Tnew_E = 2'd2; Tuse_rs_D = 2'd0;
        expect_cyc("reg0_no_stall", V_RUN);
        next_cyc();

        // Mult: start cycle plus exactly 5 busy cycles stall the md op in D
        idle_inputs();
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b0;
        expect_cyc("mult_start", V_STALL);
        next_cyc();
        md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_cyc($sformatf("mult_busy%0d", i + 1), V_STALL | V_BUSY);
            next_cyc();
        end
        expect_cyc("mult_done", V_RUN);
        next_cyc();

        // Div with Req on busy cycle 3: count runs the full 10 cycles
        md_start_E = 1'b1; md_div_E = 1'b1;
        expect_cyc("div_start", V_STALL);
        next_cyc();
        md_start_E = 1'b0; md_div_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            Req = (i == 3);
            if (i == 3) expect_cyc("div_req_busy3", V_REQ | V_BUSY);
            else        expect_cyc($sformatf("div_busy%0d", i), V_STALL | V_BUSY);
            next_cyc();
        end
        Req = 1'b0;
        expect_cyc("div_done", V_RUN);
        next_cyc();

        // Start suppressed by a simultaneous Req
        idle_inputs();
        md_start_E = 1'b1; Req = 1'b1;
        expect_cyc("simul_req", V_REQ);
        next_cyc();
        md_start_E = 1'b0; Req = 1'b0;
        expect_cyc("simul_no_busy", V_RUN);
        next_cyc();

        // Reset mid-busy: busy clears at once, no resumption afterwards
        md_start_E = 1'b1;
        expect_cyc("rst_mult_start", V_RUN);
        next_cyc();
        md_start_E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_cyc($sformatf("rst_busy%0d", i + 1), V_RUN | V_BUSY);
            next_cyc();
        end
        expect_now("rst_busy4", V_RUN | V_BUSY);
        reset = 1'b0;
        expect_now("rst_async", V_RST);
        next_cyc();
        expect_cyc("rst_held", V_RST);
        reset = 1'b1;
        next_cyc();
        expect_cyc("rst_release", V_RUN);
        next_cyc();
        expect_cyc("rst_stay_idle", V_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
